out_sched: RTL

OUT_SCHED -- requirements
Module: out_sched

---
 rtl/out_sched_if.sv | 26 ++
 rtl/out_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/out_sched_if.sv
// Bus bundle for out_sched: start request, best-array read port, output FIFO write port, status.
interface out_sched_if #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic                      send_best_arr;
  logic                      best_arr_csb;
  logic [ADDR_WIDTH-1:0]     best_arr_addr;
  logic [DATA_WIDTH-1:0]     best_arr_rdata_idx;
  logic [2*DATA_WIDTH-1:0]   best_arr_rdata_dist;
  logic                      out_fifo_wenq;
  logic [DATA_WIDTH-1:0]     out_fifo_wdata;
  logic                      out_fifo_wfull_n;
  logic                      busy;
  logic                      done;

  modport master (
    input  send_best_arr, best_arr_rdata_idx, best_arr_rdata_dist, out_fifo_wfull_n,
    output best_arr_csb, best_arr_addr, out_fifo_wenq, out_fifo_wdata, busy, done
  );

  modport slave (
    output send_best_arr, best_arr_rdata_idx, best_arr_rdata_dist, out_fifo_wfull_n,
    input  best_arr_csb, best_arr_addr, out_fifo_wenq, out_fifo_wdata, busy, done
  );
endinterface

// File: rtl/out_sched.sv
// Streams the best-match array to the output FIFO in column-blocked order:
// all index words first, then each distance as a low/high word pair.
module out_sched #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ROW_SIZE   = 26,
  parameter int unsigned COL_SIZE   = 19,
  parameter int unsigned BLOCKING   = 4,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic        io_clk,
  input  logic        io_rst_n,
  out_sched_if.master bus
);
  localparam int unsigned HALF = ROW_SIZE / 2;
  localparam int unsigned NX   = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int unsigned XW   = (NX > 1) ? $clog2(NX) : 1;
  localparam int unsigned YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int unsigned IW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
  localparam int unsigned DW2  = 2 * DATA_WIDTH;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] PUSH0   = 3'd3;
  localparam logic [2:0] PUSH1   = 3'd4;
  localparam logic [2:0] ADV     = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;

  logic [2:0]            state_q, state_d;
  logic                  px_q, px_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [IW-1:0]         xi_q, xi_d;
  logic                  phase_q, phase_d;
  logic [DW2-1:0]        dist_q, dist_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  csb_q, csb_d, busy_q, busy_d, done_q, done_d;

  logic                  n_px;
  logic [XW-1:0]         n_x;
  logic [YW-1:0]         n_y;
  logic [IW-1:0]         n_xi;
  logic                  last_tuple, n_skip;
  logic [31:0]           addr_full;

  // Next tuple in xi -> y -> x -> px carry order
  always_comb begin
    n_px = px_q;
    n_x  = x_q;
    n_y  = y_q;
    n_xi = xi_q + IW'(1);
    last_tuple = 1'b0;
    if (xi_q == IW'(BLOCKING - 1)) begin
      n_xi = '0;
      n_y  = y_q + YW'(1);
      if (y_q == YW'(COL_SIZE - 1)) begin
        n_y = '0;
        n_x = x_q + XW'(1);
        if (x_q == XW'(NX - 1)) begin
          n_x  = '0;
          n_px = ~px_q;
          last_tuple = px_q;
        end
      end
    end
    n_skip = (32'(n_x) * BLOCKING + 32'(n_xi)) >= HALF;
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    x_d     = x_q;
    y_d     = y_q;
    xi_d    = xi_q;
    phase_d = phase_q;
    dist_d  = dist_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.send_best_arr) begin
          px_d = 1'b0; x_d = '0; y_d = '0; xi_d = '0;
          phase_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        dist_d  = bus.best_arr_rdata_dist;
        wdata_d = phase_q ? bus.best_arr_rdata_dist[DATA_WIDTH-1:0] : bus.best_arr_rdata_idx;
        state_d = PUSH0;
      end
      PUSH0: begin
        if (bus.out_fifo_wfull_n) begin
          state_d = phase_q ? PUSH1 : ADV;
          if (phase_q) wdata_d = dist_q[DW2-1:DATA_WIDTH];
        end
      end
      PUSH1: if (bus.out_fifo_wfull_n) state_d = ADV;
      ADV: begin
        if (last_tuple) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            px_d = 1'b0; x_d = '0; y_d = '0; xi_d = '0;
            state_d = ISSUE;
          end else begin
            state_d = FIN;
          end
        end else begin
          px_d = n_px; x_d = n_x; y_d = n_y; xi_d = n_xi;
          // Skipped tuples cost one ADV cycle each and never reach ISSUE
          state_d = n_skip ? ADV : ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_full = 32'(px_d) * HALF + 32'(y_d) * ROW_SIZE + 32'(x_d) * BLOCKING + 32'(xi_d);
    addr_d = (state_d == ISSUE) ? ADDR_WIDTH'(addr_full) : addr_q;
    csb_d  = (state_d != ISSUE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge io_clk) begin
    if (!io_rst_n) begin
      state_q <= IDLE;
      px_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xi_q    <= '0;
      phase_q <= 1'b0;
      dist_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      csb_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xi_q    <= xi_d;
      phase_q <= phase_d;
      dist_q  <= dist_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      csb_q   <= csb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Enqueue follows wfull_n combinationally so it never fires into a full FIFO
  assign bus.out_fifo_wenq  = io_rst_n && bus.out_fifo_wfull_n &&
                              ((state_q == PUSH0) || (state_q == PUSH1));
  assign bus.out_fifo_wdata = wdata_q;
  assign bus.best_arr_csb   = csb_q;
  assign bus.best_arr_addr  = addr_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule
